// File: rtl/ttt_move_ctrl.sv
// Turn scheduler between two player button sets and the tic-tac-toe core: cursor, set strobe, turn tracking.
// Optional idle auto-move timer is compiled in when TURN_TIMER_EN is defined.
module ttt_move_ctrl #(
    parameter int CONFIRM_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 100000000,
    parameter int TMR_W          = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  p1_btn,
    input  logic [4:0]  p2_btn,
    input  logic [17:0] grid,
    input  logic        mode,
    output logic [3:0]  cursor_pos,
    output logic        set,
    output logic        turn,
    output logic        busy,
    output logic        reject
);

    localparam int CNT_W = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [3:0] CENTER = 4'd4;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_SEL   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CONFIRM = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cursor_q, cursor_d;
    logic             turn_q, turn_d;
    logic             reject_q, reject_d;
    logic [4:0]       p1_prev_q, p1_prev_d;
    logic [4:0]       p2_prev_q, p2_prev_d;
    logic [4:0]       p1_edge_q, p1_edge_d;
    logic [4:0]       p2_edge_q, p2_edge_d;
    logic             mode_prev_q, mode_prev_d;
    logic [4:0]       act_edge;
    logic             cur_blank;

    function automatic logic cell_blank(input logic [17:0] g, input logic [3:0] idx);
        logic [1:0] c;
        c = 2'b00;
        for (int k = 0; k < 9; k++) begin
            if (idx == 4'(k)) c = g[2*k +: 2];
        end
        return (c == 2'b00);
    endfunction

    // Row/column arithmetic with wrap; only the highest-priority direction is applied.
    function automatic logic [3:0] move_cursor(input logic [3:0] cur, input logic [3:0] dir);
        logic [3:0] row;
        logic [3:0] col;
        row = cur / 4'd3;
        col = cur % 4'd3;
        if (dir[BTN_UP])         row = (row == 4'd0) ? 4'd2 : row - 4'd1;
        else if (dir[BTN_DOWN])  row = (row == 4'd2) ? 4'd0 : row + 4'd1;
        else if (dir[BTN_LEFT])  col = (col == 4'd0) ? 4'd2 : col - 4'd1;
        else if (dir[BTN_RIGHT]) col = (col == 4'd2) ? 4'd0 : col + 4'd1;
        return row * 4'd3 + col;
    endfunction

`ifdef TURN_TIMER_EN
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [4:0]       first_free;

    // Returns {found, index} of the lowest-index blank cell.
    function automatic logic [4:0] first_blank(input logic [17:0] g);
        logic [4:0] r;
        r = 5'd0;
        for (int k = 8; k >= 0; k--) begin
            if (g[2*k +: 2] == 2'b00) r = {1'b1, 4'(k)};
        end
        return r;
    endfunction
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYCLES, TMR_W};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cursor_q    <= CENTER;
            turn_q      <= 1'b0;
            reject_q    <= 1'b0;
            p1_prev_q   <= 5'b11111;
            p2_prev_q   <= 5'b11111;
            p1_edge_q   <= 5'b00000;
            p2_edge_q   <= 5'b00000;
            mode_prev_q <= 1'b0;
`ifdef TURN_TIMER_EN
            tmr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cursor_q    <= cursor_d;
            turn_q      <= turn_d;
            reject_q    <= reject_d;
            p1_prev_q   <= p1_prev_d;
            p2_prev_q   <= p2_prev_d;
            p1_edge_q   <= p1_edge_d;
            p2_edge_q   <= p2_edge_d;
            mode_prev_q <= mode_prev_d;
`ifdef TURN_TIMER_EN
            tmr_q       <= tmr_d;
`endif
        end
    end

    always_comb begin
        p1_prev_d   = p1_btn;
        p2_prev_d   = p2_btn;
        p1_edge_d   = p1_btn & ~p1_prev_q;
        p2_edge_d   = p2_btn & ~p2_prev_q;
        mode_prev_d = mode;

        state_d  = state_q;
        cnt_d    = cnt_q;
        cursor_d = cursor_q;
        turn_d   = turn_q;
        reject_d = 1'b0;

        // The waiting player's edges are simply never looked at, so nothing queues.
        act_edge  = turn_q ? p2_edge_q : p1_edge_q;
        cur_blank = cell_blank(grid, cursor_q);

        if (mode) begin
            state_d = IDLE;
        end else if (mode_prev_q) begin
            // Leaving score display: the core restarts with P1 to move.
            state_d  = IDLE;
            turn_d   = 1'b0;
            cursor_d = CENTER;
        end else begin
            case (state_q)
                IDLE: begin
                    if (act_edge[BTN_SEL]) begin
                        if (cur_blank) state_d = ISSUE;
                        else           reject_d = 1'b1;
                    end else if (|act_edge[3:0]) begin
                        cursor_d = move_cursor(cursor_q, act_edge[3:0]);
                    end
                end
                ISSUE: begin
                    state_d = CONFIRM;
                    cnt_d   = '0;
                end
                CONFIRM: begin
                    if (!cur_blank) begin
                        turn_d  = ~turn_q;
                        state_d = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        reject_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

`ifdef TURN_TIMER_EN
        tmr_d      = tmr_q;
        first_free = first_blank(grid);
        if (mode || mode_prev_q || (state_q != IDLE) || (|act_edge) || (turn_d != turn_q)) begin
            tmr_d = '0;
        end else if (tmr_q == TMR_LAST) begin
            // With a full board the timer parks at its last value until something changes.
            if (first_free[4]) begin
                cursor_d = first_free[3:0];
                state_d  = ISSUE;
                tmr_d    = '0;
            end
        end else begin
            tmr_d = tmr_q + 1'b1;
        end
`endif
    end

    assign cursor_pos = cursor_q;
    assign set        = (state_q == ISSUE) && !mode;
    assign turn       = turn_q;
    assign busy       = (state_q != IDLE);
    assign reject     = reject_q;

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Bench for ttt_move_ctrl: directed scenarios with literal expectations plus randomized play
// checked every cycle against a row/column behavioural model and a stub game core.
module tb_ttt_move_ctrl;

    localparam int CONF = 4;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  p1_btn = 5'b0;
    logic [4:0]  p2_btn = 5'b0;
    logic [17:0] grid;
    logic        mode = 1'b0;
    logic [3:0]  cursor_pos;
    logic        set;
    logic        turn;
    logic        busy;
    logic        reject;

    logic [17:0] grid_base  = 18'b0;
    logic [17:0] core_marks = 18'b0;
    logic        core_en    = 1'b0;
    logic        clr_marks  = 1'b0;
    logic        cmp_en     = 1'b0;

    int n_checks = 0;
    int n_err    = 0;
    int set_cnt  = 0;

    ttt_move_ctrl #(
        .CONFIRM_CYCLES(CONF),
        .TIMEOUT_CYCLES(TMO),
        .TMR_W(27)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .p1_btn(p1_btn),
        .p2_btn(p2_btn),
        .grid(grid),
        .mode(mode),
        .cursor_pos(cursor_pos),
        .set(set),
        .turn(turn),
        .busy(busy),
        .reject(reject)
    );

    always #5 clk = ~clk;

    assign grid = grid_base | core_marks;

    // Stub game core: places the mover's mark at the cursor when strobed.
    always @(posedge clk) begin
        if (clr_marks) core_marks <= 18'b0;
        else if (core_en && set === 1'b1 && !mode && cursor_pos < 4'd9)
            core_marks[2*cursor_pos +: 2] <= turn ? 2'b10 : 2'b01;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input int p, input logic [4:0] b);
        if (p == 1) p1_btn = b; else p2_btn = b;
        cyc(1);
        p1_btn = 5'b0;
        p2_btn = 5'b0;
        cyc(1);
    endtask

    // ---------------- behavioural model ----------------
    logic [4:0] m_prev1 = 5'b11111, m_prev2 = 5'b11111;
    logic [4:0] m_pend1 = 5'b0, m_pend2 = 5'b0, m_act;
    int  m_turn = 0, m_row = 1, m_col = 1, m_phase = 0, m_wait = 0, m_tmr = 0;
    int  m_idx, m_fb, m_turn_before;
    bit  m_rej = 1'b0, m_mode_prev = 1'b0, m_blank, m_idle_before;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_prev1 = 5'b11111; m_prev2 = 5'b11111;
                m_pend1 = 5'b0;     m_pend2 = 5'b0;
                m_turn = 0; m_row = 1; m_col = 1; m_phase = 0; m_wait = 0;
                m_rej = 1'b0; m_mode_prev = 1'b0; m_tmr = 0;
            end else begin
                m_act   = (m_turn != 0) ? m_pend2 : m_pend1;
                m_pend1 = p1_btn & ~m_prev1;
                m_pend2 = p2_btn & ~m_prev2;
                m_prev1 = p1_btn;
                m_prev2 = p2_btn;
                m_idx   = m_row * 3 + m_col;
                m_blank = (grid[m_idx*2 +: 2] == 2'b00);
                m_turn_before = m_turn;
                m_idle_before = (m_phase == 0);
                m_rej = 1'b0;
                if (mode) begin
                    m_phase = 0;
                end else if (m_mode_prev) begin
                    m_turn = 0; m_row = 1; m_col = 1;
                end else if (m_phase == 0) begin
                    if (m_act[4]) begin
                        if (m_blank) m_phase = 1; else m_rej = 1'b1;
                    end
                    else if (m_act[0]) m_row = (m_row + 2) % 3;
                    else if (m_act[1]) m_row = (m_row + 1) % 3;
                    else if (m_act[2]) m_col = (m_col + 2) % 3;
                    else if (m_act[3]) m_col = (m_col + 1) % 3;
                end else if (m_phase == 1) begin
                    m_phase = 2; m_wait = 0;
                end else begin
                    if (!m_blank) begin
                        m_turn = 1 - m_turn; m_phase = 0;
                    end else if (m_wait == CONF - 1) begin
                        m_rej = 1'b1; m_phase = 0;
                    end else begin
                        m_wait++;
                    end
                end
`ifdef TURN_TIMER_EN
                if (mode || m_mode_prev || !m_idle_before || m_act != 5'b0 || m_turn != m_turn_before) begin
                    m_tmr = 0;
                end else if (m_tmr == TMO - 1) begin
                    m_fb = -1;
                    for (int k = 8; k >= 0; k--) if (grid[2*k +: 2] == 2'b00) m_fb = k;
                    if (m_fb >= 0) begin
                        m_row = m_fb / 3; m_col = m_fb % 3; m_phase = 1; m_tmr = 0;
                    end
                end else begin
                    m_tmr++;
                end
`endif
                m_mode_prev = mode;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (set === 1'b1) set_cnt++;
            if (cmp_en) begin
                chk("cursor_pos", 32'(cursor_pos), 32'(m_row * 3 + m_col));
                chk("set",        32'(set),        32'((m_phase == 1) && !mode));
                chk("turn",       32'(turn),       32'(m_turn));
                chk("busy",       32'(busy),       32'(m_phase != 0));
                chk("reject",     32'(reject),     32'(m_rej));
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    int sc;
    initial begin
        rst_n  = 1'b0;
        p1_btn = 5'b10000;
        cyc(1);
        cmp_en = 1'b1;
        cyc(2);
        chk("rst cursor", 32'(cursor_pos), 32'd4);
        chk("rst set",    32'(set),        32'd0);
        chk("rst turn",   32'(turn),       32'd0);
        chk("rst busy",   32'(busy),       32'd0);
        chk("rst reject", 32'(reject),     32'd0);

        // sel held through reset must not fire; the re-press must, once
        rst_n = 1'b1;
        cyc(5);
        chk("held sel no set", 32'(set_cnt), 32'd0);
        p1_btn = 5'b0;
        cyc(2);
        press(1, 5'b10000);
        chk("re-press set", 32'(set), 32'd1);
        chk("re-press cursor", 32'(cursor_pos), 32'd4);
        cyc(4);
        chk("confirm wait busy", 32'(busy), 32'd1);
        chk("confirm wait reject", 32'(reject), 32'd0);
        cyc(1);
        chk("confirm timeout reject", 32'(reject), 32'd1);
        chk("confirm timeout busy", 32'(busy), 32'd0);
        chk("confirm timeout turn", 32'(turn), 32'd0);
        chk("single set after re-press", 32'(set_cnt), 32'd1);

        // P1 moves to cell 6 and places X
        core_en = 1'b1;
        clr_marks = 1'b1; cyc(1); clr_marks = 1'b0;
        press(1, 5'b01000);
        chk("right 4->5", 32'(cursor_pos), 32'd5);
        press(1, 5'b01000);
        chk("right wrap 5->3", 32'(cursor_pos), 32'd3);
        press(1, 5'b00010);
        chk("down 3->6", 32'(cursor_pos), 32'd6);
        press(1, 5'b10000);
        chk("sel set latency", 32'(set), 32'd1);
        chk("sel cursor", 32'(cursor_pos), 32'd6);
        cyc(1);
        chk("after set busy", 32'(busy), 32'd1);
        cyc(1);
        chk("turn to P2", 32'(turn), 32'd1);
        chk("grid cell6 X", 32'(grid[13:12]), 32'd1);

        // P2 selects occupied cell
        press(2, 5'b10000);
        chk("occupied reject", 32'(reject), 32'd1);
        chk("occupied no set", 32'(set), 32'd0);
        cyc(1);
        chk("reject one cycle", 32'(reject), 32'd0);
        chk("turn stays P2", 32'(turn), 32'd1);

        // P1 ignored while it is P2's turn
        sc = set_cnt;
        press(1, 5'b01000);
        press(1, 5'b10000);
        cyc(1);
        chk("P1 ignored cursor", 32'(cursor_pos), 32'd6);
        chk("P1 ignored set count", 32'(set_cnt), 32'(sc));

        // P2 navigation, wrap and priority
        press(2, 5'b00001);
        chk("up 6->3", 32'(cursor_pos), 32'd3);
        press(2, 5'b00001);
        chk("up 3->0", 32'(cursor_pos), 32'd0);
        press(2, 5'b00001);
        chk("up wrap 0->6", 32'(cursor_pos), 32'd6);
        press(2, 5'b01000);
        press(2, 5'b01000);
        chk("right 6->8", 32'(cursor_pos), 32'd8);
        press(2, 5'b01001);
        chk("up beats right 8->5", 32'(cursor_pos), 32'd5);
        press(2, 5'b00010);
        chk("down 5->8", 32'(cursor_pos), 32'd8);

        // score display round trip
        mode = 1'b1;
        cyc(1);
        press(2, 5'b00100);
        chk("score no move", 32'(cursor_pos), 32'd8);
        mode = 1'b0;
        cyc(1);
        chk("score exit turn", 32'(turn), 32'd0);
        chk("score exit cursor", 32'(cursor_pos), 32'd4);

        // sel together with a direction uses the pre-move cursor
        press(1, 5'b10010);
        chk("sel+dir set", 32'(set), 32'd1);
        chk("sel+dir cursor", 32'(cursor_pos), 32'd4);
        cyc(2);
        chk("sel+dir turn", 32'(turn), 32'd1);
        chk("sel+dir cursor kept", 32'(cursor_pos), 32'd4);

        // reset in the middle of CONFIRM
        core_en = 1'b0;
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        clr_marks = 1'b1; cyc(1); clr_marks = 1'b0;
        press(1, 5'b10000);
        cyc(1);
        chk("pre-reset busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid-confirm reset busy", 32'(busy), 32'd0);
        chk("mid-confirm reset cursor", 32'(cursor_pos), 32'd4);
        chk("mid-confirm reset turn", 32'(turn), 32'd0);
        sc = set_cnt;
        cyc(2);
        rst_n = 1'b1;
        cyc(6);
        chk("no set after reset", 32'(set_cnt), 32'(sc));

`ifdef TURN_TIMER_EN
        rst_n = 1'b0;
        grid_base = 18'h00019;
        cyc(2);
        rst_n = 1'b1;
        cyc(15);
        chk("timer cycle 15 no set", 32'(set), 32'd0);
        cyc(1);
        chk("timer auto set", 32'(set), 32'd1);
        chk("timer auto cursor", 32'(cursor_pos), 32'd3);
        cyc(6);
        grid_base = 18'b0;
`endif

        // randomized play
        core_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(599) != 0);
            p1_btn = 5'($urandom) & 5'($urandom) & 5'($urandom);
            p2_btn = 5'($urandom) & 5'($urandom) & 5'($urandom);
            if (mode) mode = ($urandom_range(3) != 0);
            else      mode = ($urandom_range(99) == 0);
            core_en   = ($urandom_range(7) != 0);
            clr_marks = (i % 60 == 0);
            cyc(1);
        end
        rst_n = 1'b1;
        p1_btn = 5'b0;
        p2_btn = 5'b0;
        clr_marks = 1'b0;
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
